fp_mul_seq: RTL and testbench

Parametrised, sequential IEEE-754-style floating-point multiplier that supersedes the single-precision combinational multiplier in the multipliers group. It accepts operands over a valid/ready handshake and forms the significand product with an iterative shift-add engine (one bit per cycle). It normalises, rounds to nearest-even, and returns the product with exception flags. Zero, Inf and NaN operands take a short bypass path. It sits between the ALU operand bus and the result writeback stage.

---
 rtl/fp_mul_pkg.sv | 53 +++++
 rtl/fp_mul_seq_if.sv | 30 +++
 rtl/fp_mul_shift_add.sv | 50 +++++
 rtl/fp_mul_seq.sv | 186 ++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier:
// FSM state encoding, operand class decode and special-value constructors.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_SUB    = 3'd1,
        CLS_INF    = 3'd2,
        CLS_NAN    = 3'd3,
        CLS_NORMAL = 3'd4
    } fp_class_e;

    // Widest word the constructors can build; callers size-cast down to their width.
    localparam int FP_MAX_W = 64;

    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        fp_class_e cls;
        if (exp_zero) begin
            cls = frac_zero ? CLS_ZERO : CLS_SUB;
        end else if (exp_ones) begin
            cls = frac_zero ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_exp_ones(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        return fp_exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        return (64'(sign) << (exp_w + man_w)) | fp_exp_ones(exp_w, man_w);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_zero(input logic sign, input int exp_w, input int man_w);
        return 64'(sign) << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle between the ALU operand bus, the multiplier
// and the writeback stage.
interface fp_mul_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Product;
    logic         flag_ovf;
    logic         flag_unf;
    logic         flag_inv;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Product, flag_ovf, flag_unf, flag_inv
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Product, flag_ovf, flag_unf, flag_inv
    );

endinterface

// File: rtl/fp_mul_shift_add.sv
// Iterative unsigned N x N multiplier: one multiplier bit per cycle, shift-add
// into a 2N-bit accumulator. 'last' is high during the cycle of the final add.
module fp_mul_shift_add #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           last,
    output logic [2*N-1:0] acc
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_r;
    logic [2*N-1:0] acc_r;
    logic [N-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;

    // Load on start, then one conditional add and shift per cycle until the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (start) begin
            mcand_r  <= {{N{1'b0}}, mcand};
            mplier_r <= mplier;
            acc_r    <= '0;
            cnt_r    <= CW'(N);
        end else if (cnt_r != '0) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CW'(1);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign last = (cnt_r == CW'(1));
    assign acc  = acc_r;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: handshake FSM, exponent path, RNE rounding
// and a one-cycle special-operand bypass around the shift-add significand engine.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_mul_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NW = MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);

    state_e state_r, next_state_s;

    logic                 accept_s;
    fp_class_e            a_cls_s, b_cls_s;
    logic                 res_sign_s, special_s, spec_inv_s;
    logic [W-1:0]         spec_res_s;
    logic signed [EW-1:0] esum_s;

    logic                 sign_r, special_r, spec_inv_r;
    logic [W-1:0]         spec_res_r;
    logic signed [EW-1:0] esum_r;
    logic [W-1:0]         product_r;
    logic                 ovf_r, unf_r, inv_r;

    logic                 eng_start_s, eng_last_s;
    logic [2*NW-1:0]      acc_s, norm_s;
    logic signed [EW-1:0] exp_n_s, exp_r_s;
    logic [MAN_W-1:0]     frac_s;
    logic                 g_s, r_s, st_s, inc_s;
    logic [MAN_W:0]       frac_rnd_s;
    logic [W-1:0]         norm_res_s;
    logic                 norm_ovf_s, norm_unf_s;

    assign accept_s    = bus.in_valid && (state_r == ST_IDLE);
    assign eng_start_s = accept_s && !special_s;

    fp_mul_shift_add #(.N(NW)) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start_s),
        .mcand  ({1'b1, bus.A[MAN_W-1:0]}),
        .mplier ({1'b1, bus.B[MAN_W-1:0]}),
        .last   (eng_last_s),
        .acc    (acc_s)
    );

    // Classify incoming operands and pre-build the bypass result and biased exponent sum.
    always_comb begin
        a_cls_s    = fp_classify(bus.A[W-2:MAN_W] == '0, &bus.A[W-2:MAN_W], bus.A[MAN_W-1:0] == '0);
        b_cls_s    = fp_classify(bus.B[W-2:MAN_W] == '0, &bus.B[W-2:MAN_W], bus.B[MAN_W-1:0] == '0);
        res_sign_s = bus.A[W-1] ^ bus.B[W-1];
        special_s  = (a_cls_s != CLS_NORMAL) || (b_cls_s != CLS_NORMAL);
        spec_inv_s = (a_cls_s == CLS_NAN) || (b_cls_s == CLS_NAN) ||
                     ((a_cls_s == CLS_INF) && (b_cls_s == CLS_ZERO)) ||
                     ((a_cls_s == CLS_ZERO) && (b_cls_s == CLS_INF));
        if (spec_inv_s) begin
            spec_res_s = W'(fp_qnan(EXP_W, MAN_W));
        end else if ((a_cls_s == CLS_INF) || (b_cls_s == CLS_INF)) begin
            spec_res_s = W'(fp_inf(res_sign_s, EXP_W, MAN_W));
        end else begin
            spec_res_s = W'(fp_zero(res_sign_s, EXP_W, MAN_W));
        end
        esum_s = $signed({2'b00, bus.A[W-2:MAN_W]}) + $signed({2'b00, bus.B[W-2:MAN_W]}) - E_BIAS;
    end

    // Normalise the raw product, round to nearest-even and range-check the exponent.
    always_comb begin
        norm_s     = acc_s[2*NW-1] ? acc_s : (acc_s << 1);
        exp_n_s    = esum_r + $signed({{(EW-1){1'b0}}, acc_s[2*NW-1]});
        frac_s     = norm_s[2*NW-2 -: MAN_W];
        g_s        = norm_s[MAN_W];
        r_s        = norm_s[MAN_W-1];
        st_s       = |norm_s[MAN_W-2:0];
        inc_s      = g_s && (r_s || st_s || frac_s[0]);
        frac_rnd_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, inc_s};
        exp_r_s    = frac_rnd_s[MAN_W] ? (exp_n_s + E_ONE) : exp_n_s;
        norm_ovf_s = 1'b0;
        norm_unf_s = 1'b0;
        if (exp_r_s >= E_MAX) begin
            norm_res_s = W'(fp_inf(sign_r, EXP_W, MAN_W));
            norm_ovf_s = 1'b1;
        end else if (exp_r_s <= E_ZERO) begin
            norm_res_s = W'(fp_zero(sign_r, EXP_W, MAN_W));
            norm_unf_s = 1'b1;
        end else begin
            norm_res_s = {sign_r, exp_r_s[EXP_W-1:0], frac_rnd_s[MAN_W-1:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; special operands spend one MUL cycle before presenting the result.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_MUL;
                else          next_state_s = ST_IDLE;
            end
            ST_MUL: begin
                if (special_r)       next_state_s = ST_DONE;
                else if (eng_last_s) next_state_s = ST_NORM;
                else                 next_state_s = ST_MUL;
            end
            ST_NORM: next_state_s = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) next_state_s = ST_IDLE;
                else               next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operand context capture and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r     <= 1'b0;
            special_r  <= 1'b0;
            spec_inv_r <= 1'b0;
            spec_res_r <= '0;
            esum_r     <= '0;
            product_r  <= '0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
            inv_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_r     <= res_sign_s;
                        special_r  <= special_s;
                        spec_inv_r <= spec_inv_s;
                        spec_res_r <= spec_res_s;
                        esum_r     <= esum_s;
                        ovf_r      <= 1'b0;
                        unf_r      <= 1'b0;
                        inv_r      <= 1'b0;
                    end else begin
                        special_r  <= special_r;
                    end
                end
                ST_MUL: begin
                    if (special_r) begin
                        product_r <= spec_res_r;
                        inv_r     <= spec_inv_r;
                    end else begin
                        product_r <= product_r;
                    end
                end
                ST_NORM: begin
                    product_r <= norm_res_s;
                    ovf_r     <= norm_ovf_s;
                    unf_r     <= norm_unf_s;
                end
                default: begin
                    product_r <= product_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.Product   = product_r;
    assign bus.flag_ovf  = ovf_r;
    assign bus.flag_unf  = unf_r;
    assign bus.flag_inv  = inv_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq in single precision and a 5/10 half format.
module tb_fp_mul_seq;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus32();
    fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus16();

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic [2:0] f, output int lat);
        bus32.A        = a;
        bus32.B        = b;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        p = bus32.Product;
        f = {bus32.flag_ovf, bus32.flag_unf, bus32.flag_inv};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_handshake got=%b exp=%b", {bus32.in_ready, bus32.out_valid}, 2'b10);
        end
        checks++;
        if ({bus32.Product, bus32.flag_ovf, bus32.flag_unf, bus32.flag_inv} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {bus32.Product, bus32.flag_ovf, bus32.flag_unf, bus32.flag_inv});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
        run32(32'h40A80000, 32'h400CCCCD, p, f, lat);
        checks++;
        if (p !== 32'h4138CCCD) begin
            failures++;
            $display("FAIL mul_5p25x2p2 got=%h exp=%h", p, 32'h4138CCCD);
        end
        checks++;
        if (f !== 3'b000) begin
            failures++;
            $display("FAIL mul_5p25x2p2_flags got=%b exp=%b", f, 3'b000);
        end
        checks++;
        if (lat !== 25) begin
            failures++;
            $display("FAIL mul_latency got=%0d exp=%0d", lat, 25);
        end
    endtask

    task automatic test_rne_sign();
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
        run32(32'hBE99999A, 32'h43FA2000, p, f, lat);
        checks++;
        if ({p, f} !== {32'hC3161334, 3'b000}) begin
            failures++;
            $display("FAIL rne_neg0p3x500p25 got=%h/%b exp=%h/000", p, f, 32'hC3161334);
        end
        run32(32'h40A80000, 32'hC00CCCCD, p, f, lat);
        checks++;
        if ({p, f} !== {32'hC138CCCD, 3'b000}) begin
            failures++;
            $display("FAIL sign_5p25xneg2p2 got=%h/%b exp=%h/000", p, f, 32'hC138CCCD);
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [3] = '{32'h00000000, 32'h7F800000, 32'h7FC00001};
        logic [31:0] vb [3] = '{32'h40A80000, 32'h00000000, 32'h3F800000};
        logic [31:0] vp [3] = '{32'h00000000, 32'h7FC00000, 32'h7FC00000};
        logic [2:0]  vf [3] = '{3'b000, 3'b001, 3'b001};
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], p, f, lat);
            checks++;
            if ({p, f} !== {vp[i], vf[i]}) begin
                failures++;
                $display("FAIL special_%0d got=%h/%b exp=%h/%b", i, p, f, vp[i], vf[i]);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL special_latency_%0d got=%0d exp=1", i, lat);
            end
        end
    endtask

    task automatic test_ovf_unf();
        logic [31:0] va [3] = '{32'h7F000000, 32'h00800000, 32'h00000001};
        logic [31:0] vb [3] = '{32'h7F000000, 32'h3F000000, 32'h40000000};
        logic [31:0] vp [3] = '{32'h7F800000, 32'h00000000, 32'h00000000};
        logic [2:0]  vf [3] = '{3'b100, 3'b010, 3'b000};
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], p, f, lat);
            checks++;
            if ({p, f} !== {vp[i], vf[i]}) begin
                failures++;
                $display("FAIL range_%0d got=%h/%b exp=%h/%b", i, p, f, vp[i], vf[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat;
        bus32.out_ready = 1'b0;
        bus32.A         = 32'h3FC00000;
        bus32.B         = 32'h3FC00000;
        bus32.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid  = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            bus32.A        = 32'h3F800000 + i;
            bus32.in_valid = i[0];
            @(posedge clk); #1;
            checks++;
            if ({bus32.Product, bus32.in_ready, bus32.out_valid} !== {32'h40100000, 2'b01}) begin
                failures++;
                $display("FAIL hold_%0d got=%h/%b%b exp=40100000/01", i, bus32.Product, bus32.in_ready, bus32.out_valid);
            end
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL release_idle got=%b exp=10", {bus32.in_ready, bus32.out_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        logic [2:0]  f;
        int          lat;
        bus32.A        = 32'h3FC00000;
        bus32.B        = 32'h3FC00000;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus32.in_ready, bus32.out_valid, bus32.Product, bus32.flag_ovf, bus32.flag_unf, bus32.flag_inv}
                !== {2'b10, 35'd0}) begin
            failures++;
            $display("FAIL reset_mid got=%b%b/%h exp=10/0", bus32.in_ready, bus32.out_valid, bus32.Product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run32(32'h3FC00000, 32'h3FC00000, p, f, lat);
        checks++;
        if ({p, f} !== {32'h40100000, 3'b000}) begin
            failures++;
            $display("FAIL after_reset_1p5sq got=%h/%b exp=40100000/000", p, f);
        end
        checks++;
        if (lat !== 25) begin
            failures++;
            $display("FAIL after_reset_latency got=%0d exp=25", lat);
        end
    endtask

    task automatic test_half();
        int lat;
        bus16.A        = 16'h3E00;
        bus16.B        = 16'h3E00;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({bus16.Product, bus16.flag_ovf, bus16.flag_unf, bus16.flag_inv} !== {16'h4080, 3'b000}) begin
            failures++;
            $display("FAIL half_1p5sq got=%h exp=%h", bus16.Product, 16'h4080);
        end
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL half_latency got=%0d exp=12", lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.A         = 32'h0;
        bus32.B         = 32'h0;
        bus32.out_ready = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.A         = 16'h0;
        bus16.B         = 16'h0;
        bus16.out_ready = 1'b1;
        test_reset();
        test_normal();
        test_rne_sign();
        test_specials();
        test_ovf_unf();
        test_handshake();
        test_reset_mid();
        test_half();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
